// File: rtl/coco_alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// coco_alu_arbiter_if
// Bundles every bus of the two-port ALU arbiter:
//   - requester ports 0/1 : reqN_valid/a/b/ctrl in, reqN_ready out
//   - response ports 0/1  : rspN_valid out, rspN_ready in, shared rsp_c/ovf/cmp
//   - shared ALU          : alu_a/alu_b/alu_ctrl out, alu_c/alu_ovf/alu_cmp in
//   - busy                : arbiter status
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and ALU's view (the environment)
// -----------------------------------------------------------------------------
interface coco_alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
);
   logic              req0_valid, req1_valid;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
   logic              req0_ready, req1_ready;

   logic              rsp0_valid, rsp1_valid;
   logic              rsp0_ready, rsp1_ready;
   logic [DATA_W-1:0] rsp_c;
   logic              rsp_ovf, rsp_cmp;

   logic [DATA_W-1:0] alu_a, alu_b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [DATA_W-1:0] alu_c;
   logic              alu_ovf, alu_cmp;

   logic              busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready,
             alu_c, alu_ovf, alu_cmp,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp_c, rsp_ovf, rsp_cmp, alu_a, alu_b, alu_ctrl, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready,
             alu_c, alu_ovf, alu_cmp,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
             rsp_c, rsp_ovf, rsp_cmp, alu_a, alu_b, alu_ctrl, busy
   );
endinterface

// File: rtl/coco_alu_arbiter.sv
// -----------------------------------------------------------------------------
// coco_alu_arbiter
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: IDLE (arbitrate + latch operands), EXEC (drive ALU,
// capture result), RESP (hold result until the winner takes it).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : coco_alu_arbiter_if.slave (requests, responses, ALU, busy)
// Configuration:
//   COCO_ALU_ARB_RR_EN defined   : round-robin between simultaneous requests
//   COCO_ALU_ARB_RR_EN undefined : fixed priority, port 0 wins
// -----------------------------------------------------------------------------
module coco_alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   coco_alu_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            r_state, w_next;
   logic              w_grant0, w_grant1;
   logic              r_win;            // 0: port 0 owns the operation, 1: port 1
   logic [DATA_W-1:0] r_a, r_b, r_c;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_ovf, r_cmp;

`ifdef COCO_ALU_ARB_RR_EN
   logic r_ptr;                         // 0 favours port 0, 1 favours port 1

   always_comb begin
      w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
      w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_ptr);
   end

   // After any grant the pointer favours the port that just lost or was idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= 1'b0;
      else if (r_state == IDLE && (w_grant0 | w_grant1))
         r_ptr <= w_grant0;
   end
`else
   assign w_grant0 = bus.req0_valid;
   assign w_grant1 = bus.req1_valid & ~bus.req0_valid;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      w_next         = r_state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      bus.busy       = 1'b0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.alu_ctrl   = '0;
      case (r_state)
         IDLE: begin
            // Accept is combinational so a withdrawn request never sees ready;
            // gated by rst_n so reset holds both ready lines low.
            bus.req0_ready = w_grant0 & rst_n;
            bus.req1_ready = w_grant1 & rst_n;
            if (w_grant0 | w_grant1)
               w_next = EXEC;
         end
         EXEC: begin
            bus.busy     = 1'b1;
            bus.alu_a    = r_a;
            bus.alu_b    = r_b;
            bus.alu_ctrl = r_ctrl;
            w_next       = RESP;
         end
         RESP: begin
            bus.busy       = 1'b1;
            bus.alu_a      = r_a;
            bus.alu_b      = r_b;
            bus.alu_ctrl   = r_ctrl;
            bus.rsp0_valid = ~r_win;
            bus.rsp1_valid =  r_win;
            // Only the owner's ready counts; the other port's ready is ignored.
            if (r_win ? bus.rsp1_ready : bus.rsp0_ready)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // NOTE: operand and result registers are reset so an abandoned operation
   // leaves nothing visible on rsp_c/flags or the ALU bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win  <= 1'b0;
         r_a    <= '0;
         r_b    <= '0;
         r_ctrl <= '0;
         r_c    <= '0;
         r_ovf  <= 1'b0;
         r_cmp  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0 | w_grant1) begin
                  r_win  <= w_grant1;
                  r_a    <= w_grant1 ? bus.req1_a    : bus.req0_a;
                  r_b    <= w_grant1 ? bus.req1_b    : bus.req0_b;
                  r_ctrl <= w_grant1 ? bus.req1_ctrl : bus.req0_ctrl;
               end
            end
            EXEC: begin
               r_c   <= bus.alu_c;
               r_ovf <= bus.alu_ovf;
               r_cmp <= bus.alu_cmp;
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_c   = r_c;
   assign bus.rsp_ovf = r_ovf;
   assign bus.rsp_cmp = r_cmp;

endmodule

// File: tb/tb_coco_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_coco_alu_arbiter
// Self-checking bench for coco_alu_arbiter with a behavioural ALU.
// ALU control codes used here: ADDU=0, SUBU=1, BEQ=2, BNE=3.
//   ADDU: c=a+b, ovf=carry out      SUBU: c=a-b, ovf=borrow (a<b)
//   BEQ : c=0,   cmp=(a==b)         BNE : c=0,   cmp=(a!=b)
// Expected arbitration order follows COCO_ALU_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_coco_alu_arbiter;

   localparam logic [4:0] ADDU = 5'd0;
   localparam logic [4:0] SUBU = 5'd1;
   localparam logic [4:0] BEQ  = 5'd2;
   localparam logic [4:0] BNE  = 5'd3;

`ifdef COCO_ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   coco_alu_arbiter_if #(.DATA_W(32), .CTRL_W(5)) bus ();

   coco_alu_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU.
   always_comb begin
      logic [32:0] sum;
      sum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_c   = 32'd0;
      bus.alu_ovf = 1'b0;
      bus.alu_cmp = 1'b0;
      case (bus.alu_ctrl)
         ADDU: begin bus.alu_c = sum[31:0]; bus.alu_ovf = sum[32]; end
         SUBU: begin bus.alu_c = bus.alu_a - bus.alu_b; bus.alu_ovf = bus.alu_a < bus.alu_b; end
         BEQ:  bus.alu_cmp = (bus.alu_a == bus.alu_b);
         BNE:  bus.alu_cmp = (bus.alu_a != bus.alu_b);
         default: ;
      endcase
   end

   typedef struct {
      logic        port;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  ctrl;
      logic [31:0] exp_c;
      logic        exp_ovf;
      logic        exp_cmp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic port, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] ctrl);
      if (port == 1'b0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
      end
   endtask

   // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle.
   task automatic run_op(input vec_t v, input string tag);
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      set_req(v.port, 1'b1, v.a, v.b, v.ctrl);
      #1;
      check({tag, " ready"},     {31'd0, v.port ? bus.req1_ready : bus.req0_ready}, 32'd1);
      check({tag, " other rdy"}, {31'd0, v.port ? bus.req0_ready : bus.req1_ready}, 32'd0);
      @(negedge clk);                                   // EXEC
      set_req(v.port, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      check({tag, " exec busy"},  {31'd0, bus.busy}, 32'd1);
      check({tag, " exec alu_a"}, bus.alu_a, v.a);
      @(negedge clk);                                   // RESP
      #1;
      check({tag, " rsp_valid"}, {31'd0, v.port ? bus.rsp1_valid : bus.rsp0_valid}, 32'd1);
      check({tag, " other rsp"}, {31'd0, v.port ? bus.rsp0_valid : bus.rsp1_valid}, 32'd0);
      check({tag, " rsp_c"},     bus.rsp_c, v.exp_c);
      check({tag, " rsp_ovf"},   {31'd0, bus.rsp_ovf}, {31'd0, v.exp_ovf});
      check({tag, " rsp_cmp"},   {31'd0, bus.rsp_cmp}, {31'd0, v.exp_cmp});
      @(negedge clk);                                   // IDLE
      #1;
      check({tag, " idle busy"},  {31'd0, bus.busy}, 32'd0);
      check({tag, " idle alu_a"}, bus.alu_a, 32'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int acc0, acc1, k;

      vecs[0] = '{1'b0, 32'd5,          32'd7,      ADDU, 32'd12,         1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'hFFFF_FFFF,  32'd1,      ADDU, 32'd0,          1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'd3,          32'd5,      SUBU, 32'hFFFF_FFFE,  1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'd10,         32'd4,      SUBU, 32'd6,          1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h1234,       32'h1234,   BEQ,  32'd0,          1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'h1234,       32'h1234,   BNE,  32'd0,          1'b0, 1'b0};
      vecs[6] = '{1'b0, 32'h1234,       32'h1235,   BNE,  32'd0,          1'b0, 1'b1};

      // Reset state, with a request already pending.
      rst_n = 1'b0;
      set_req(1'b0, 1'b1, 32'd9, 32'd9, ADDU);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      #12;
      check("reset req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      check("reset busy",       {31'd0, bus.busy}, 32'd0);
      check("reset rsp_c",      bus.rsp_c, 32'd0);
      check("reset alu_a",      bus.alu_a, 32'd0);
      check("reset rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven single operations.
      for (int i = 0; i < 7; i++)
         run_op(vecs[i], $sformatf("vec%0d", i));

      // Port 1 stalls in RESP for 10 cycles; port 0 waits, its stray ready ignored.
      bus.rsp1_ready = 1'b0;
      bus.rsp0_ready = 1'b1;
      set_req(1'b1, 1'b1, 32'd3, 32'd5, SUBU);
      #1;
      check("stall req1_ready", {31'd0, bus.req1_ready}, 32'd1);
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      set_req(1'b0, 1'b1, 32'd5, 32'd7, ADDU);
      #1;
      check("stall exec req0_ready", {31'd0, bus.req0_ready}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("stall%0d rsp1_valid", i), {31'd0, bus.rsp1_valid}, 32'd1);
         check($sformatf("stall%0d rsp_c", i),      bus.rsp_c, 32'hFFFF_FFFE);
         check($sformatf("stall%0d req0_ready", i), {31'd0, bus.req0_ready}, 32'd0);
         check($sformatf("stall%0d rsp0_valid", i), {31'd0, bus.rsp0_valid}, 32'd0);
         @(negedge clk);
      end
      bus.rsp1_ready = 1'b1;
      @(negedge clk);                                   // IDLE, port 0 pending
      #1;
      check("post-stall req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      @(negedge clk);
      #1;
      check("post-stall rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
      check("post-stall rsp_c",      bus.rsp_c, 32'd12);
      @(negedge clk);

      // Withdrawn request: port 1 raises valid during EXEC, drops it in RESP.
      set_req(1'b0, 1'b1, 32'd1, 32'd2, ADDU);
      @(negedge clk);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      set_req(1'b1, 1'b1, 32'd7, 32'd7, ADDU);
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      #1;
      check("withdraw rsp_c", bus.rsp_c, 32'd3);
      @(negedge clk);
      #1;
      check("withdraw busy0",      {31'd0, bus.busy}, 32'd0);
      check("withdraw req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      @(negedge clk);
      #1;
      check("withdraw busy1", {31'd0, bus.busy}, 32'd0);

      // Reset during EXEC abandons the operation.
      set_req(1'b0, 1'b1, 32'd5, 32'd7, ADDU);
      @(negedge clk);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      rst_n = 1'b0;
      #1;
      check("rst-exec busy",  {31'd0, bus.busy}, 32'd0);
      check("rst-exec alu_a", bus.alu_a, 32'd0);
      check("rst-exec rsp_c", bus.rsp_c, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("rst-exec%0d rsp0_valid", i), {31'd0, bus.rsp0_valid}, 32'd0);
         check($sformatf("rst-exec%0d busy", i),       {31'd0, bus.busy}, 32'd0);
         @(negedge clk);
      end
      run_op(vecs[0], "post-reset");

      // Both ports requesting continuously from a fresh pointer.
      pulse_reset();
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      set_req(1'b0, 1'b1, 32'd1, 32'd1, ADDU);
      set_req(1'b1, 1'b1, 32'd2, 32'd2, ADDU);
      acc0 = 0;
      acc1 = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         k = cyc / 3;
         #1;
         if (cyc % 3 == 0) begin
            check($sformatf("arb%0d req0_ready", cyc), {31'd0, bus.req0_ready},
                  (RR && (k % 2 == 1)) ? 32'd0 : 32'd1);
            check($sformatf("arb%0d req1_ready", cyc), {31'd0, bus.req1_ready},
                  (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
         end
         if (cyc % 3 == 2)
            check($sformatf("arb%0d rsp1_valid", cyc), {31'd0, bus.rsp1_valid},
                  (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
         if (bus.req0_ready) acc0++;
         if (bus.req1_ready) acc1++;
         @(negedge clk);
      end
      check("arb accepts port0", acc0, RR ? 32'd2 : 32'd4);
      check("arb accepts port1", acc1, RR ? 32'd2 : 32'd0);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
